tdc_measure_ctrl: RTL

Measurement sequencer for the tapped delay line time-to-digital converter. It arms the converter, accepts single-cycle start/stop pulses from the edge detectors, and snapshots the registered delay-line tap vector on each event. It thermometer-decodes each snapshot to a fine count and counts coarse clock cycles between start and stop. It returns one result per measurement over a valid/ready handshake, with a timeout flag.

---
 rtl/tdc_measure_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tdc_measure_ctrl.sv
// Measurement sequencer for a tapped-delay-line TDC: arm, start/stop capture,
// thermometer fine decode, coarse cycle count, valid/ready result, timeout.
// Ports: clk, rst (sync, active-high), arm, abort, start_edge, stop_edge,
//   taps_in[TAPS], busy, armed, res_valid, res_ready, res_coarse[COARSE_W],
//   res_fine_start/res_fine_stop[FINE_W], res_timeout.
// Option: define TDC_AUTO_REARM_EN to re-arm after every result handshake.
module tdc_measure_ctrl #(
  parameter int TAPS     = 64,
  parameter int COARSE_W = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         start_edge,
  input  logic                         stop_edge,
  input  logic [TAPS-1:0]              taps_in,
  output logic                         busy,
  output logic                         armed,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [COARSE_W-1:0]          res_coarse,
  output logic [$clog2(TAPS+1)-1:0]    res_fine_start,
  output logic [$clog2(TAPS+1)-1:0]    res_fine_stop,
  output logic                         res_timeout
);

  localparam int FINE_W = $clog2(TAPS+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [COARSE_W-1:0] count_q;
  logic [FINE_W-1:0]   fine_now;
  logic                at_limit;
  logic                cap_start;
  logic                fin_stop;
  logic                fin_to;
  logic                cnt_inc;

  // Count the run of ones starting at tap 0; anything past the first zero
  // is a bubble and must not contribute.
  function automatic logic [FINE_W-1:0] decode(input logic [TAPS-1:0] t);
    logic              run;
    logic [FINE_W-1:0] n;
    run = 1'b1;
    n   = '0;
    for (int i = 0; i < TAPS; i++) begin
      run = run & t[i];
      n   = n + FINE_W'(run);
    end
    return n;
  endfunction

  assign fine_now = decode(taps_in);
  assign at_limit = (count_q == COARSE_W'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    cap_start = 1'b0;
    fin_stop  = 1'b0;
    fin_to    = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (start_edge) begin
          state_d   = RUNNING;
          cap_start = 1'b1;
        end
      end
      RUNNING: begin
        // stop has priority over the timeout on the same cycle
        if (stop_edge) begin
          state_d  = DONE;
          fin_stop = 1'b1;
        end else if (at_limit) begin
          state_d = DONE;
          fin_to  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
`ifdef TDC_AUTO_REARM_EN
          state_d = ARMED;
`else
          state_d = IDLE;
`endif
        end
      end
    endcase
    if (abort) begin
      state_d   = IDLE;
      cap_start = 1'b0;
      fin_stop  = 1'b0;
      fin_to    = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      res_coarse     <= '0;
      res_fine_start <= '0;
      res_fine_stop  <= '0;
      res_timeout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (abort) begin
        count_q <= '0;
      end else if (cap_start) begin
        count_q <= COARSE_W'(1);
      end else if (cnt_inc) begin
        count_q <= count_q + COARSE_W'(1);
      end
      if (cap_start) begin
        res_fine_start <= fine_now;
      end
      if (fin_stop) begin
        res_coarse    <= count_q;
        res_fine_stop <= fine_now;
        res_timeout   <= 1'b0;
      end else if (fin_to) begin
        res_coarse    <= COARSE_W'(TIMEOUT);
        res_fine_stop <= '0;
        res_timeout   <= 1'b1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign armed     = (state_q == ARMED);
  assign res_valid = (state_q == DONE);

endmodule
